// File: rtl/out_collect_bram_ctrl_pkg.sv
// out_collect_bram_ctrl_pkg: mode encodings, batch word counts and read FSM states
package out_collect_bram_ctrl_pkg;
    localparam int WCNT_W = 11;
    localparam logic [1:0] MODE_512      = 2'd0;
    localparam logic [1:0] MODE_1024     = 2'd1;
    localparam logic [1:0] MODE_1024_ALT = 2'd2;
    localparam logic [1:0] MODE_2048     = 2'd3;
    localparam logic [WCNT_W-1:0] WORDS_256  = 11'd256;
    localparam logic [WCNT_W-1:0] WORDS_512  = 11'd512;
    localparam logic [WCNT_W-1:0] WORDS_1024 = 11'd1024;
    typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_t;
    function automatic logic [WCNT_W-1:0] words_for_mode(input logic [1:0] mode);
        return (mode == MODE_1024 || mode == MODE_1024_ALT) ? WORDS_512 :
               (mode == MODE_2048) ? WORDS_1024 :
               (mode == MODE_512) ? WORDS_256 : WORDS_512;
    endfunction
endpackage

// File: rtl/out_collect_bram_ctrl_if.sv
// out_collect_bram_ctrl_if: result input stream and packed valid/ready output
interface out_collect_bram_ctrl_if #(
    parameter int DATA_IN_W  = 128,
    parameter int DATA_OUT_W = 256
);
    logic [DATA_IN_W-1:0]  i_res_in;
    logic                  i_res_vld;
    logic [1:0]            i_mode;
    logic                  i_out_ready;
    logic [DATA_OUT_W-1:0] o_out_data;
    logic                  o_out_vld;
    logic                  o_out_last;
    logic                  o_batch_done;
    logic                  o_overflow;
    modport master (
        output i_res_in, i_res_vld, i_mode, i_out_ready,
        input  o_out_data, o_out_vld, o_out_last, o_batch_done, o_overflow
    );
    modport slave (
        input  i_res_in, i_res_vld, i_mode, i_out_ready,
        output o_out_data, o_out_vld, o_out_last, o_batch_done, o_overflow
    );
endinterface

// File: rtl/out_collect_bram_ctrl_bram.sv
// BRAM: simple dual-port block RAM with a registered read and a read-valid flag
module BRAM #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rd_data_vld
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
        o_rd_data_vld <= i_re;
    end
endmodule

// File: rtl/out_collect_bram_ctrl.sv
// out_collect_bram_ctrl: packs result pairs into ping-pong BRAM banks and drains full banks
module out_collect_bram_ctrl
    import out_collect_bram_ctrl_pkg::*;
#(
    parameter int DATA_IN_W  = 128,
    parameter int DATA_OUT_W = 256,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input logic clk,
    input logic rst,
    out_collect_bram_ctrl_if.slave bus
);
    logic                  r_wr_bank, r_half, r_batch_done, r_overflow;
    logic [DATA_IN_W-1:0]  r_hold;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [WCNT_W-1:0]     r_words_tgt;
    logic [WCNT_W-1:0]     r_cnt [2];
    logic [1:0]            r_full, w_set, w_clr;
    logic                  w_acc, w_we, w_wlast;
    rd_state_t             r_state, w_state_nxt;
    logic                  r_rd_bank, r_out_last;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_OUT_W-1:0] r_out_data;
    logic [DATA_OUT_W-1:0] w_rdata [2];
    logic [1:0]            w_rvld;
    logic                  w_rd_vld, w_re, w_load, w_hs, w_is_last, w_send;

    assign w_acc   = bus.i_res_vld & ~r_full[r_wr_bank];
    assign w_we    = w_acc & r_half;
    assign w_wlast = w_we & ({1'b0, r_wr_addr} == r_words_tgt - WCNT_W'(1));
    assign w_set   = w_wlast ? (2'b01 << r_wr_bank) : 2'b00;

    // Dropped results leave half, hold and address untouched so the batch resumes cleanly
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_bank    <= 1'b0;
            r_half       <= 1'b0;
            r_hold       <= '0;
            r_wr_addr    <= '0;
            r_words_tgt  <= '0;
            r_full       <= '0;
            r_cnt[0]     <= '0;
            r_cnt[1]     <= '0;
            r_batch_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_full       <= (r_full | w_set) & ~w_clr;
            r_batch_done <= w_wlast;
            if (bus.i_res_vld && r_full[r_wr_bank]) r_overflow <= 1'b1;
            if (w_acc) r_half <= ~r_half;
            if (w_acc && !r_half) r_hold <= bus.i_res_in;
            if (w_acc && !r_half && r_wr_addr == '0) r_words_tgt <= words_for_mode(bus.i_mode);
            if (w_we) r_wr_addr <= w_wlast ? '0 : r_wr_addr + ADDR_WIDTH'(1);
            if (w_wlast) begin
                r_cnt[r_wr_bank] <= r_words_tgt;
                r_wr_bank        <= ~r_wr_bank;
            end
        end
    end

    assign w_send    = r_state == SEND;
    assign w_rd_vld  = w_rvld[r_rd_bank];
    assign w_hs      = w_send & bus.i_out_ready;
    assign w_is_last = {1'b0, r_rd_addr} == r_cnt[r_rd_bank] - WCNT_W'(1);
    assign w_clr     = (w_hs && r_out_last) ? (2'b01 << r_rd_bank) : 2'b00;

    // IDLE also looks at this cycle's full set so the fetch starts right after the last write
    always_comb begin
        w_state_nxt = r_state;
        w_re        = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE:    w_state_nxt = (r_full[r_rd_bank] | w_set[r_rd_bank]) ? FETCH : IDLE;
            FETCH: begin
                w_re        = ~w_rd_vld;
                w_load      = w_rd_vld;
                w_state_nxt = w_rd_vld ? SEND : FETCH;
            end
            SEND:    w_state_nxt = w_hs ? (r_out_last ? IDLE : FETCH) : SEND;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_addr  <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_out_data <= w_rdata[r_rd_bank];
                r_out_last <= w_is_last;
            end
            if (w_hs) begin
                r_rd_addr <= r_out_last ? '0 : r_rd_addr + ADDR_WIDTH'(1);
                if (r_out_last) r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        BRAM #(.DATA_WIDTH(DATA_OUT_W), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bram (
            .clk           (clk),
            .i_we          (w_we && r_wr_bank == 1'(b)),
            .i_waddr       (r_wr_addr),
            .i_wdata       ({r_hold, bus.i_res_in}),
            .i_re          (w_re && r_rd_bank == 1'(b)),
            .i_raddr       (r_rd_addr),
            .o_rdata       (w_rdata[b]),
            .o_rd_data_vld (w_rvld[b])
        );
    end

    assign bus.o_out_data   = r_out_data;
    assign bus.o_out_vld    = w_send;
    assign bus.o_out_last   = r_out_last & w_send;
    assign bus.o_batch_done = r_batch_done;
    assign bus.o_overflow   = r_overflow;
endmodule

// File: tb/tb_out_collect_bram_ctrl.sv
// tb_out_collect_bram_ctrl: scoreboard bench, driver pushes expected words, monitor pops on handshake
module tb_out_collect_bram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    out_collect_bram_ctrl_if bus ();
    out_collect_bram_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [255:0] data;
        logic         last;
    } exp_t;

    exp_t         q [$];
    exp_t         mon_e;
    int           checks = 0;
    int           failures = 0;
    int           hs_cnt = 0;
    int           last_cnt = 0;
    int           done_cnt = 0;
    int           rdy_mode = 0;
    int           base;
    bit           mon_en = 1'b0;
    int unsigned  seq = 0;
    logic [127:0] prev_res = '0;
    logic         stalled = 1'b0;
    logic [255:0] held = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] res_val(input int unsigned n);
        return {n, ~n, n ^ 32'h5A5A_5A5A, 32'hC0DE_0000 + n};
    endfunction

    task automatic send(input int n, input bit push, input bit mark_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.i_res_vld = 1'b1;
            bus.i_res_in  = res_val(seq);
            if (push && i % 2 == 1)
                q.push_back('{data: {prev_res, bus.i_res_in}, last: mark_last && i == n - 1});
            prev_res = bus.i_res_in;
            seq++;
        end
        @(posedge clk); #1;
        bus.i_res_vld = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while (q.size() != 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 256'(q.size()), 256'(0));
    endtask

    task automatic wait_last(input int target);
        int cyc = 0;
        while (last_cnt < target && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_last", 256'(last_cnt), 256'(target));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.i_out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.i_out_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 99) < 30);
        end
    end

    always @(negedge clk) begin
        if (bus.o_batch_done) done_cnt++;
        if (mon_en) begin
            if (stalled) begin
                check("stall_vld", 256'(bus.o_out_vld), 256'(1));
                check("stall_data", bus.o_out_data, held);
            end
            if (bus.o_out_vld && bus.i_out_ready) begin
                hs_cnt++;
                if (bus.o_out_last) last_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", bus.o_out_data);
                end else begin
                    mon_e = q.pop_front();
                    check("out_data", bus.o_out_data, mon_e.data);
                    check("out_last", 256'(bus.o_out_last), 256'(mon_e.last));
                end
            end
            stalled = bus.o_out_vld && !bus.i_out_ready;
            held    = bus.o_out_data;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        bus.i_res_in  = '0;
        bus.i_res_vld = 1'b0;
        bus.i_mode    = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_vld", 256'(bus.o_out_vld), 256'(0));
        check("rst_out_last", 256'(bus.o_out_last), 256'(0));
        check("rst_batch_done", 256'(bus.o_batch_done), 256'(0));
        check("rst_overflow", 256'(bus.o_overflow), 256'(0));
        check("rst_out_data", bus.o_out_data, 256'(0));
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // mode 0, free-running drain, start latency
        bus.i_mode = 2'd0;
        rdy_mode   = 1;
        base       = done_cnt;
        send(512, 1'b1, 1'b1);
        @(negedge clk);
        check("lat_k1_vld", 256'(bus.o_out_vld), 256'(0));
        check("lat_k1_done", 256'(bus.o_batch_done), 256'(1));
        @(negedge clk);
        check("lat_k2_vld", 256'(bus.o_out_vld), 256'(0));
        @(negedge clk);
        check("lat_k3_vld", 256'(bus.o_out_vld), 256'(1));
        wait_drain("t1_drain");
        check("t1_done_cnt", 256'(done_cnt - base), 256'(1));
        check("t1_overflow", 256'(bus.o_overflow), 256'(0));

        // mode 3 then mode 1
        base       = done_cnt;
        bus.i_mode = 2'd3;
        send(2048, 1'b1, 1'b1);
        bus.i_mode = 2'd1;
        send(1024, 1'b1, 1'b1);
        wait_drain("t2_drain");
        check("t2_done_cnt", 256'(done_cnt - base), 256'(2));
        check("t2_overflow", 256'(bus.o_overflow), 256'(0));

        // random backpressure, three mode-2 batches
        rdy_mode   = 2;
        bus.i_mode = 2'd2;
        base       = last_cnt;
        send(1024, 1'b1, 1'b1);
        send(1024, 1'b1, 1'b1);
        wait_last(base + 1);
        send(1024, 1'b1, 1'b1);
        wait_drain("t3_drain");
        check("t3_overflow", 256'(bus.o_overflow), 256'(0));
        rdy_mode = 1;

        // mode change mid-batch is ignored
        base       = done_cnt;
        bus.i_mode = 2'd0;
        send(100, 1'b1, 1'b0);
        bus.i_mode = 2'd3;
        send(412, 1'b1, 1'b1);
        wait_drain("t4_drain");
        check("t4_done_cnt", 256'(done_cnt - base), 256'(1));
        check("t4_overflow", 256'(bus.o_overflow), 256'(0));

        // overflow with stalled output
        rdy_mode   = 0;
        bus.i_mode = 2'd0;
        base       = done_cnt;
        send(512, 1'b1, 1'b1);
        send(512, 1'b1, 1'b1);
        check("t5_ovf_before", 256'(bus.o_overflow), 256'(0));
        @(posedge clk); #1;
        bus.i_res_vld = 1'b1;
        bus.i_res_in  = res_val(seq);
        seq++;
        @(negedge clk);
        check("t5_ovf_first_cycle", 256'(bus.o_overflow), 256'(0));
        @(posedge clk); #1;
        bus.i_res_vld = 1'b0;
        @(negedge clk);
        check("t5_ovf_rise", 256'(bus.o_overflow), 256'(1));
        send(511, 1'b0, 1'b0);
        rdy_mode = 1;
        wait_drain("t5_drain");
        check("t5_ovf_sticky", 256'(bus.o_overflow), 256'(1));
        check("t5_done_cnt", 256'(done_cnt - base), 256'(2));
        do_reset();
        @(negedge clk);
        check("t5_ovf_cleared", 256'(bus.o_overflow), 256'(0));

        // reset mid-batch and mid-drain
        rdy_mode = 0;
        send(512, 1'b1, 1'b1);
        send(101, 1'b0, 1'b0);
        rdy_mode = 1;
        base     = hs_cnt;
        for (int c = 0; c < 2000 && hs_cnt < base + 10; c++) @(negedge clk);
        check("t6_partial_drain", 256'(hs_cnt - base >= 10), 256'(1));
        @(posedge clk); #1;
        mon_en   = 1'b0;
        rdy_mode = 0;
        rst      = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_out_vld", 256'(bus.o_out_vld), 256'(0));
        check("t6_out_last", 256'(bus.o_out_last), 256'(0));
        check("t6_batch_done", 256'(bus.o_batch_done), 256'(0));
        check("t6_overflow", 256'(bus.o_overflow), 256'(0));
        check("t6_out_data", bus.o_out_data, 256'(0));
        q.delete();
        mon_en   = 1'b1;
        rdy_mode = 1;
        base     = done_cnt;
        send(512, 1'b1, 1'b1);
        wait_drain("t6_drain");
        check("t6_done_cnt", 256'(done_cnt - base), 256'(1));
        check("t6_overflow_end", 256'(bus.o_overflow), 256'(0));

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
